// File: rtl/bfly_output_merger_pkg.sv
// Shared types and constants for the butterfly output merger.
package bfly_output_merger_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } merge_state_e;

  localparam logic PORT_A    = 1'b0;
  localparam logic PORT_B    = 1'b1;

  localparam logic ARB_RR    = 1'b0;
  localparam logic ARB_FIXED = 1'b1;

  // Choose a port among eligible ones; caller guarantees at least one is eligible.
  function automatic logic pick_port(input logic arb_mode, input logic rr,
                                     input logic elig_a, input logic elig_b);
    logic sel;
    if (arb_mode == ARB_FIXED) begin
      sel = elig_a ? PORT_A : PORT_B;
    end else if (rr == PORT_A) begin
      sel = elig_a ? PORT_A : PORT_B;
    end else begin
      sel = elig_b ? PORT_B : PORT_A;
    end
    return sel;
  endfunction

endpackage

// File: rtl/bfly_merge_fifo.sv
// Synchronous FIFO with occupancy output and registered ready (= not full).
module bfly_merge_fifo #(
  parameter int unsigned DATA_W = 384,
  parameter int unsigned DEPTH  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_push,
  input  logic [DATA_W-1:0]         i_dat,
  input  logic                      i_pop,
  output logic [DATA_W-1:0]         o_head,
  output logic                      o_rdy,
  output logic [$clog2(DEPTH):0]    o_occ
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PW-1:0]     r_wr;
  logic [PW-1:0]     r_rd;
  logic              r_rdy;

  logic              w_push;
  logic              w_pop;
  logic [PW-1:0]     w_wr_nxt;
  logic [PW-1:0]     w_rd_nxt;
  logic              w_full_nxt;

  assign w_push     = i_push & r_rdy;
  assign w_pop      = i_pop & (r_wr != r_rd);
  assign w_wr_nxt   = r_wr + PW'(w_push);
  assign w_rd_nxt   = r_rd + PW'(w_pop);
  assign w_full_nxt = (w_wr_nxt[AW] != w_rd_nxt[AW]) &&
                      (w_wr_nxt[AW-1:0] == w_rd_nxt[AW-1:0]);

  assign o_head = r_mem[r_rd[AW-1:0]];
  assign o_occ  = r_wr - r_rd;
  assign o_rdy  = r_rdy;

  // Pointer and ready update; ready reflects fullness after this cycle's push/pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_rdy <= 1'b0;
    end else begin
      r_wr  <= w_wr_nxt;
      r_rd  <= w_rd_nxt;
      r_rdy <= ~w_full_nxt;
    end
  end

  // Storage write; contents need no reset since pointers gate visibility.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr[AW-1:0]] <= i_dat;
    end
  end

endmodule

// File: rtl/bfly_output_merger.sv
// Merges two butterfly output streams into bursts for the DDR writer.
module bfly_output_merger
  import bfly_output_merger_pkg::*;
#(
  parameter int unsigned DATA_W     = 384,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned BURST_LEN  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arb_mode,
  input  logic              flush,
  input  logic              up_vld_A,
  input  logic [DATA_W-1:0] up_dat_A,
  output logic              up_rdy_A,
  input  logic              up_vld_B,
  input  logic [DATA_W-1:0] up_dat_B,
  output logic              up_rdy_B,
  output logic              dn_vld,
  output logic [DATA_W-1:0] dn_dat,
  input  logic              dn_rdy,
  output logic              dn_port,
  output logic              dn_last,
  output logic [15:0]       burst_cnt
);

  localparam int unsigned OCC_W = $clog2(FIFO_DEPTH) + 1;

  merge_state_e      r_state;
  logic              r_grant;
  logic              r_rr;
  logic [OCC_W-1:0]  r_beats_left;
  logic              r_dn_vld;
  logic              r_dn_last;
  logic [15:0]       r_burst_cnt;

  logic [OCC_W-1:0]  w_occ_a;
  logic [OCC_W-1:0]  w_occ_b;
  logic [DATA_W-1:0] w_head_a;
  logic [DATA_W-1:0] w_head_b;
  logic              w_elig_a;
  logic              w_elig_b;
  logic              w_sel;
  logic [OCC_W-1:0]  w_sel_occ;
  logic [OCC_W-1:0]  w_first_len;
  logic              w_hs;
  logic              w_pop_a;
  logic              w_pop_b;

  bfly_merge_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo_a (
    .clk    (clk),
    .rst    (rst),
    .i_push (up_vld_A),
    .i_dat  (up_dat_A),
    .i_pop  (w_pop_a),
    .o_head (w_head_a),
    .o_rdy  (up_rdy_A),
    .o_occ  (w_occ_a)
  );

  bfly_merge_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo_b (
    .clk    (clk),
    .rst    (rst),
    .i_push (up_vld_B),
    .i_dat  (up_dat_B),
    .i_pop  (w_pop_b),
    .o_head (w_head_b),
    .o_rdy  (up_rdy_B),
    .o_occ  (w_occ_b)
  );

  // A port may start a burst once it holds a full burst, or anything at all under flush.
  assign w_elig_a    = (w_occ_a >= OCC_W'(BURST_LEN)) || (flush && (w_occ_a != '0));
  assign w_elig_b    = (w_occ_b >= OCC_W'(BURST_LEN)) || (flush && (w_occ_b != '0));
  assign w_sel       = pick_port(arb_mode, r_rr, w_elig_a, w_elig_b);
  assign w_sel_occ   = (w_sel == PORT_A) ? w_occ_a : w_occ_b;
  assign w_first_len = (w_sel_occ < OCC_W'(BURST_LEN)) ? w_sel_occ : OCC_W'(BURST_LEN);

  assign w_hs    = r_dn_vld & dn_rdy;
  assign w_pop_a = w_hs & (r_grant == PORT_A);
  assign w_pop_b = w_hs & (r_grant == PORT_B);

  assign dn_vld    = r_dn_vld;
  assign dn_dat    = (r_grant == PORT_B) ? w_head_b : w_head_a;
  assign dn_port   = r_grant;
  assign dn_last   = r_dn_last;
  assign burst_cnt = r_burst_cnt;

  // Burst FSM: arbitrate in IDLE, stream the granted FIFO's head in BURST.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_grant      <= PORT_A;
      r_rr         <= PORT_A;
      r_beats_left <= '0;
      r_dn_vld     <= 1'b0;
      r_dn_last    <= 1'b0;
      r_burst_cnt  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_elig_a || w_elig_b) begin
            r_state      <= ST_BURST;
            r_grant      <= w_sel;
            r_rr         <= ~w_sel;
            r_beats_left <= w_first_len;
            r_dn_vld     <= 1'b1;
            r_dn_last    <= (w_first_len == OCC_W'(1));
          end
        end
        ST_BURST: begin
          if (w_hs) begin
            if (r_beats_left == OCC_W'(1)) begin
              r_state      <= ST_IDLE;
              r_beats_left <= '0;
              r_dn_vld     <= 1'b0;
              r_dn_last    <= 1'b0;
              r_burst_cnt  <= r_burst_cnt + 16'd1;
            end else begin
              r_beats_left <= r_beats_left - OCC_W'(1);
              r_dn_last    <= (r_beats_left == OCC_W'(2));
            end
          end
        end
      endcase
    end
  end

endmodule
